chunked_seq_adder: RTL

Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operation CHUNK bits per clock. A registered carry is chained between chunks. Operands enter over a valid/ready input handshake, and the result leaves over a valid/ready output handshake. It replaces the fixed-width ripple adder in the multiplier datapath: it trades latency for a short carry chain and adds subtraction and overflow flags.

---
 rtl/chunked_seq_adder_if.sv | 27 ++
 rtl/chunked_seq_adder.sv | 113 +++++++++++
 2 files changed

// File: rtl/chunked_seq_adder_if.sv
// Operand/result handshake bundle for chunked_seq_adder.
// master drives operands and out_ready; slave is the adder.
interface chunked_seq_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/chunked_seq_adder.sv
// Multi-cycle adder/subtractor: WIDTH bits processed CHUNK bits per clock
// with a registered carry between chunks; valid/ready on both sides.
module chunked_seq_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input logic                clk,
  input logic                rst,
  chunked_seq_adder_if.slave bus
);
  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned CS     = CHUNK + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] op_a, op_a_nx, op_b, op_b_nx;
  logic [WIDTH-1:0] res, res_nx, s_q, s_nx;
  logic             carry, carry_nx;
  logic             cout_q, cout_nx, ovf_q, ovf_nx;
  logic             in_ready_q, in_ready_nx, out_valid_q, out_valid_nx;

  logic [CHUNK-1:0] ca, cb;
  logic [CS-1:0]    csum;
  logic             c_msb;
  logic             last;

  // Current chunk slice and its sum; c_msb is the carry into the chunk MSB.
  always_comb begin
    ca    = op_a[32'(cnt) * CHUNK +: CHUNK];
    cb    = op_b[32'(cnt) * CHUNK +: CHUNK];
    csum  = {1'b0, ca} + {1'b0, cb} + CS'(carry);
    c_msb = ca[CHUNK-1] ^ cb[CHUNK-1] ^ csum[CHUNK-1];
    last  = (cnt == CW'(NCHUNK - 1));
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    op_a_nx  = op_a;
    op_b_nx  = op_b;
    res_nx   = res;
    carry_nx = carry;
    s_nx     = s_q;
    cout_nx  = cout_q;
    ovf_nx   = ovf_q;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          op_a_nx  = bus.a;
          op_b_nx  = bus.sub ? ~bus.b : bus.b;
          carry_nx = bus.sub ? 1'b1 : bus.cin;
          cnt_nx   = '0;
          state_nx = RUN;
        end
      end
      RUN: begin
        res_nx[32'(cnt) * CHUNK +: CHUNK] = csum[CHUNK-1:0];
        carry_nx = csum[CHUNK];
        if (last) begin
          s_nx     = res_nx;
          cout_nx  = csum[CHUNK];
          ovf_nx   = c_msb ^ csum[CHUNK];
          state_nx = DONE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    in_ready_nx  = (state_nx == IDLE);
    out_valid_nx = (state_nx == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      op_a        <= '0;
      op_b        <= '0;
      res         <= '0;
      carry       <= 1'b0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      op_a        <= op_a_nx;
      op_b        <= op_b_nx;
      res         <= res_nx;
      carry       <= carry_nx;
      s_q         <= s_nx;
      cout_q      <= cout_nx;
      ovf_q       <= ovf_nx;
      in_ready_q  <= in_ready_nx;
      out_valid_q <= out_valid_nx;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule
